// File: rtl/uart_alu_interface.sv
// Frame bridge: pops A, B, opcode bytes from the UART RX FIFO, presents them to a
// combinational ALU, and pushes the one-byte result into the UART TX FIFO.
module uart_alu_interface #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 260000,
    parameter int TO_BIT  = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic             wr_uart,
    output logic [DBIT-1:0]  w_data,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    input  logic [DBIT-1:0]  alu_result,
    output logic             frame_err
);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        COMPUTE,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [DBIT-1:0]   a_q, a_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [NB_OP-1:0]  op_q, op_d;
    logic [DBIT-1:0]   w_q, w_d;
    logic [TO_BIT-1:0] cnt_q, cnt_d;
    logic              ferr_q, ferr_d;

    logic in_wait;
    logic terminal;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        w_d      = w_q;
        cnt_d    = '0;
        ferr_d   = 1'b0;
        in_wait  = (state_q == WAIT_A) || (state_q == WAIT_B) || (state_q == WAIT_OP);
        terminal = (cnt_q == TO_BIT'(TIMEOUT - 1));

        case (state_q)
            WAIT_A: begin
                if (!rx_empty) begin
                    a_d     = r_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (!rx_empty) begin
                    b_d     = r_data;
                    state_d = WAIT_OP;
                end else if (terminal) begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_OP: begin
                // A byte arriving on the terminal count still completes the frame.
                if (!rx_empty) begin
                    op_d    = r_data[NB_OP-1:0];
                    state_d = COMPUTE;
                end else if (terminal) begin
                    ferr_d  = 1'b1;
                    state_d = WAIT_A;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMPUTE: begin
                w_d     = alu_result;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_full) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    // Strobes are Mealy so back-to-back bytes pop on consecutive cycles; a reset
    // cycle suppresses both so no byte is lost or duplicated.
    assign rd_uart = !reset && in_wait && !rx_empty;
    assign wr_uart = !reset && (state_q == SEND) && !tx_full;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign w_data    = w_q;
    assign frame_err = ferr_q;

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- FSM bridge between the UART core's FIFO-side ports and a combinational ALU.
- Pops a 3-byte frame (operand A, operand B, opcode) from the RX FIFO, drives registered operands to the ALU, captures the ALU result, and pushes it as one byte into the TX FIFO.
- Sits directly downstream of the UART RX FIFO and upstream of the UART TX FIFO.
- An inter-byte timeout discards partial frames so the link resynchronises after a lost byte.

Parameters:
- DBIT, 8, data/operand width; equals the UART byte width.
- NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third frame byte.
- TIMEOUT, 260000, max clk cycles allowed between consecutive bytes of one frame. At 50 MHz / 19200 baud this is ~10 byte times.
- TO_BIT, 18, counter width; must satisfy 2^TO_BIT > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_empty  in  1  RX FIFO empty flag; r_data is valid when 0.
- r_data  in  DBIT  RX FIFO head word.
- rd_uart  out  1  RX FIFO pop strobe, one cycle per byte.
- tx_full  in  1  TX FIFO full flag.
- wr_uart  out  1  TX FIFO push strobe.
- w_data  out  DBIT  byte to the TX FIFO (the result register).
- alu_a  out  DBIT  operand A register.
- alu_b  out  DBIT  operand B register.
- alu_op  out  NB_OP  opcode register.
- alu_result  in  DBIT  combinational ALU output.
- frame_err  out  1  one-cycle pulse when a partial frame is dropped on timeout.

Behaviour:
- Reset: state=WAIT_A; alu_a, alu_b, alu_op, w_data, timeout counter=0; frame_err=0; rd_uart=wr_uart=0. Reset has priority over every other event.
- rd_uart and wr_uart are combinational (Mealy) from state and FIFO flags. All other outputs are registered.
- Capture rule: in WAIT_A, WAIT_B or WAIT_OP with rx_empty=0:
  - rd_uart=1 that cycle;
  - r_data is latched at the same edge;
  - the state advances.
  - Never more than one pop per cycle. Back-to-back bytes are popped on consecutive cycles.
- WAIT_A: on capture, alu_a<=r_data, counter<=0, go to WAIT_B. No timeout in this state.
- WAIT_B: on capture, alu_b<=r_data, counter<=0, go to WAIT_OP.
- WAIT_OP: on capture, alu_op<=r_data[NB_OP-1:0] (upper bits ignored), go to COMPUTE.
- Timeout (WAIT_B and WAIT_OP):
  - When no capture occurs, the counter increments each cycle.
  - When counter==TIMEOUT-1 and rx_empty=1: next state=WAIT_A, counter<=0, frame_err=1 for exactly the next cycle.
  - alu_a, alu_b and alu_op keep their old values.
  - A capture in the same cycle as the terminal count wins; no error is flagged.
- COMPUTE: single cycle; w_data<=alu_result; go to SEND. Operands are stable here because they were registered one cycle earlier.
- SEND:
  - If tx_full=0: wr_uart=1 for that cycle, then go to WAIT_A.
  - If tx_full=1: wr_uart=0 and the block waits indefinitely in SEND, with no timeout and w_data held.
- Latency: wr_uart is asserted 2 cycles after the opcode's rd_uart cycle when the TX FIFO is not full.
- Bytes arriving during COMPUTE or SEND remain in the RX FIFO and start the next frame; rd_uart=0 in those states.
- alu_a, alu_b and alu_op hold until overwritten by the next frame.
- Reset mid-frame, or while stalled in SEND: the partial or pending result is dropped, no wr_uart is issued, and the block returns to WAIT_A with registers cleared.
- No arithmetic inside the block. Widths are passed through unchanged and the opcode is truncated to NB_OP bits.

Test Plan:
- Nominal frame: TIMEOUT=20, ALU model A+B for op 0x20. RX FIFO holds 0x05, 0x03, 0x20.
  - Expect 3 consecutive rd_uart pulses with alu_a=0x05, alu_b=0x03, alu_op=0x20.
  - Expect a single wr_uart pulse with w_data=0x08, 2 cycles after the third pop.
- Spaced bytes: bytes presented 10 cycles apart (less than TIMEOUT).
  - Frame completes with no frame_err.
  - Result for 0xFF+0x01 is 0x00, confirming wrap to DBIT bits.
- Timeout: push 0x11 only, then idle.
  - frame_err pulses once, 20 cycles after the pop.
  - Then push 0x02, 0x03, 0x20: result 0x05 (0x11 discarded).
- TX backpressure: tx_full=1 during SEND for 15 cycles.
  - wr_uart stays 0 and w_data is held.
  - After release, exactly one wr_uart.
  - Bytes queued meanwhile stay unpopped until the return to WAIT_A.
- Reset mid-frame: reset for 1 cycle after A and B are accepted.
  - All outputs return to 0 and no wr_uart follows.
  - Next frame 0x04, 0x04, 0x20 yields 0x08.
- Opcode truncation: third byte 0xE0 with NB_OP=6 gives alu_op=0x20.
